sha3_sponge_ctrl: RTL and testbench

Sponge sequencer for the SHA3 core. Accepts the AXI-stream message, drives word-load strobes into the 1600-bit state loader, inserts the padding step and sequences the Keccak-f permutation once per rate block. It raises a digest-ready handshake after the final permutation. It sits between the stream input, the state register/loader and the permutation round core.

---
 rtl/sha3_sponge_ctrl_if.sv | 11 +
 rtl/sha3_sponge_ctrl.sv | 179 +++++++++++++++++
 tb/tb_sha3_sponge_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha3_sponge_ctrl_if.sv
// Stream handshake bundle feeding the SHA3 sponge sequencer.
// The producer drives the master side and the sequencer the slave side.
interface sha3_sponge_ctrl_if;
    logic       TVALID;
    logic       TREADY;
    logic       TLAST;
    logic [1:0] TID;

    modport master (output TVALID, output TLAST, output TID, input TREADY);
    modport slave  (input TVALID, input TLAST, input TID, output TREADY);
endinterface

// File: rtl/sha3_sponge_ctrl.sv
// Sponge sequencer: absorbs stream beats into rate-block slots, inserts padding, runs one permutation per block.
// Optional permutation watchdog with sticky error state is enabled by defining SHA3_CTRL_WDT_EN.
module sha3_sponge_ctrl #(
    parameter int DATA_WIDTH   = 16,
    parameter int PERM_TIMEOUT = 64
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    sha3_sponge_ctrl_if.slave     axis,
    output logic                  ld_en,
    output logic [7:0]            ld_idx,
    output logic                  pad_en,
    output logic [7:0]            pad_idx,
    output logic [1:0]            pad_mode,
    output logic [7:0]            rate_words,
    output logic                  perm_start,
    input  logic                  perm_done,
    output logic                  dgst_valid,
    input  logic                  dgst_ready,
    output logic                  st_clr,
    output logic                  busy,
    output logic                  err
);

    // One-hot encoding so each Moore strobe is a single state flop.
    typedef enum logic [6:0] {
        ST_IDLE   = 7'b0000001,
        ST_ABSORB = 7'b0000010,
        ST_PAD    = 7'b0000100,
        ST_PSTART = 7'b0001000,
        ST_PWAIT  = 7'b0010000,
        ST_OUT    = 7'b0100000
`ifdef SHA3_CTRL_WDT_EN
        , ST_ERR  = 7'b1000000
`endif
    } state_t;

    if (((576 % DATA_WIDTH) != 0) || (PERM_TIMEOUT < 1)) begin : g_illegal_cfg
    end

    function automatic logic [7:0] rate_words_f(input logic [1:0] mode);
        logic [10:0] bits_v;
        case (mode)
            2'd0:    bits_v = 11'd1152;
            2'd1:    bits_v = 11'd1088;
            2'd2:    bits_v = 11'd832;
            2'd3:    bits_v = 11'd576;
            default: bits_v = 11'd1152;
        endcase
        return 8'(bits_v / 11'(DATA_WIDTH));
    endfunction

    state_t     state_r;
    logic [7:0] cnt_r;
    logic [1:0] pad_mode_r;
    logic [7:0] pad_idx_r;
    logic       pend_pad_r;
    logic       pad_done_r;
`ifdef SHA3_CTRL_WDT_EN
    localparam int WDT_W = $clog2(PERM_TIMEOUT + 1);
    logic [WDT_W-1:0] wdt_cnt_r;
`endif

    logic       tready_s;
    logic       beat_s;
    logic [7:0] cnt_base_s;
    logic [7:0] cnt_nxt_s;
    logic [7:0] blk_rate_s;
    logic       blk_full_s;

    // The first beat of a message is checked against the mode it carries, not the stale latched one.
    assign tready_s   = !ARESET && ((state_r == ST_IDLE) || (state_r == ST_ABSORB));
    assign beat_s     = axis.TVALID && tready_s;
    assign cnt_base_s = (state_r == ST_IDLE) ? 8'd0 : cnt_r;
    assign cnt_nxt_s  = cnt_base_s + 8'd1;
    assign blk_rate_s = (state_r == ST_IDLE) ? rate_words_f(axis.TID) : rate_words_f(pad_mode_r);
    assign blk_full_s = (cnt_nxt_s == blk_rate_s);

    assign axis.TREADY = tready_s;
    assign ld_en       = beat_s;
    assign ld_idx      = (state_r == ST_ABSORB) ? cnt_r : 8'd0;
    assign pad_en      = (state_r == ST_PAD);
    assign pad_idx     = pad_idx_r;
    assign pad_mode    = pad_mode_r;
    assign rate_words  = rate_words_f(pad_mode_r);
    assign perm_start  = (state_r == ST_PSTART);
    assign dgst_valid  = (state_r == ST_OUT);
    assign st_clr      = !ARESET && (state_r == ST_OUT) && dgst_ready;
    assign busy        = (state_r != ST_IDLE);
`ifdef SHA3_CTRL_WDT_EN
    assign err         = (state_r == ST_ERR);
`else
    assign err         = 1'b0;
`endif

    // Sponge sequencing FSM with block counter and padding flags.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 8'd0;
            pad_mode_r <= 2'd0;
            pad_idx_r  <= 8'd0;
            pend_pad_r <= 1'b0;
            pad_done_r <= 1'b0;
`ifdef SHA3_CTRL_WDT_EN
            wdt_cnt_r  <= '0;
`endif
        end else begin
            case (state_r)
                ST_IDLE, ST_ABSORB: begin
                    if (beat_s) begin
                        if (state_r == ST_IDLE) begin
                            pad_mode_r <= axis.TID;
                        end
                        cnt_r <= cnt_nxt_s;
                        if (axis.TLAST && !blk_full_s) begin
                            pad_idx_r <= cnt_nxt_s;
                            state_r   <= ST_PAD;
                        end else if (axis.TLAST) begin
                            pend_pad_r <= 1'b1;
                            state_r    <= ST_PSTART;
                        end else if (blk_full_s) begin
                            state_r <= ST_PSTART;
                        end else begin
                            state_r <= ST_ABSORB;
                        end
                    end
                end
                ST_PAD: begin
                    pad_done_r <= 1'b1;
                    pend_pad_r <= 1'b0;
                    state_r    <= ST_PSTART;
                end
                ST_PSTART: begin
                    cnt_r   <= 8'd0;
`ifdef SHA3_CTRL_WDT_EN
                    wdt_cnt_r <= '0;
`endif
                    state_r <= ST_PWAIT;
                end
                ST_PWAIT: begin
                    if (perm_done) begin
                        if (pad_done_r) begin
                            state_r <= ST_OUT;
                        end else if (pend_pad_r) begin
                            pad_idx_r <= cnt_r;
                            state_r   <= ST_PAD;
                        end else begin
                            state_r <= ST_ABSORB;
                        end
                    end
`ifdef SHA3_CTRL_WDT_EN
                    else if (wdt_cnt_r == WDT_W'(PERM_TIMEOUT - 1)) begin
                        state_r <= ST_ERR;
                    end else begin
                        wdt_cnt_r <= wdt_cnt_r + WDT_W'(1);
                    end
`endif
                end
                ST_OUT: begin
                    if (dgst_ready) begin
                        pad_done_r <= 1'b0;
                        pend_pad_r <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
`ifdef SHA3_CTRL_WDT_EN
                ST_ERR: begin
                    state_r <= ST_ERR;
                end
`endif
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha3_sponge_ctrl.sv
// Directed bench for sha3_sponge_ctrl: single-beat, block-boundary, multi-block, gapped and reset scenarios.
module tb_sha3_sponge_ctrl;

    logic       ACLK = 1'b0;
    logic       ARESET;
    logic       ld_en;
    logic [7:0] ld_idx;
    logic       pad_en;
    logic [7:0] pad_idx;
    logic [1:0] pad_mode;
    logic [7:0] rate_words;
    logic       perm_start;
    logic       perm_done;
    logic       dgst_valid;
    logic       dgst_ready;
    logic       st_clr;
    logic       busy;
    logic       err;

    int total = 0;
    int bad   = 0;
    int ps_cnt = 0;
    int clr_cnt = 0;
    int ld_bad = 0;
    int rdy_bad = 0;
    bit stall_chk = 1'b0;
    int base_v;

    sha3_sponge_ctrl_if axis ();

    sha3_sponge_ctrl dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .axis       (axis),
        .ld_en      (ld_en),
        .ld_idx     (ld_idx),
        .pad_en     (pad_en),
        .pad_idx    (pad_idx),
        .pad_mode   (pad_mode),
        .rate_words (rate_words),
        .perm_start (perm_start),
        .perm_done  (perm_done),
        .dgst_valid (dgst_valid),
        .dgst_ready (dgst_ready),
        .st_clr     (st_clr),
        .busy       (busy),
        .err        (err)
    );

    always #5 ACLK = ~ACLK;

    // Mid-cycle event counters for pulses and handshake-rule violations.
    always @(negedge ACLK) begin
        #2;
        if (perm_start === 1'b1) ps_cnt++;
        if (st_clr === 1'b1) clr_cnt++;
        if (ld_en === 1'b1 && axis.TREADY !== 1'b1) ld_bad++;
        if (stall_chk && axis.TREADY !== 1'b0) rdy_bad++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=hung expected=finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge ACLK);
    endtask

    task automatic beat(input logic [1:0] tid, input logic last, input logic [7:0] idx);
        axis.TVALID = 1'b1;
        axis.TLAST  = last;
        axis.TID    = tid;
        #1;
        chk("beat_ld_en", ld_en, 1'b1);
        chk("beat_ld_idx", ld_idx, idx);
        tick();
        axis.TVALID = 1'b0;
        axis.TLAST  = 1'b0;
        #1;
    endtask

    task automatic do_perm(input int lat);
        int k = 0;
        while (perm_start !== 1'b1 && k < 8) begin
            tick();
            k++;
        end
        chk("perm_start_seen", perm_start, 1'b1);
        repeat (lat) tick();
        perm_done = 1'b1;
        tick();
        perm_done = 1'b0;
        #1;
    endtask

    task automatic handshake();
        dgst_ready = 1'b1;
        axis.TVALID = 1'b0;
        #1;
        chk("hs_st_clr", st_clr, 1'b1);
        tick();
        stall_chk  = 1'b0;
        dgst_ready = 1'b0;
        #1;
        chk("hs_idle_ready", axis.TREADY, 1'b1);
        chk("hs_st_clr_low", st_clr, 1'b0);
    endtask

    initial begin
        ARESET      = 1'b1;
        axis.TVALID = 1'b1;
        axis.TLAST  = 1'b0;
        axis.TID    = 2'd0;
        perm_done   = 1'b0;
        dgst_ready  = 1'b0;
        repeat (3) tick();
        #1;
        chk("rst_tready", axis.TREADY, 1'b0);
        chk("rst_ld_en", ld_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rate", rate_words, 8'd72);
        chk("rst_pad_mode", pad_mode, 2'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_dgst", dgst_valid, 1'b0);
        axis.TVALID = 1'b0;
        ARESET = 1'b0;
        tick();

        // single beat, SHA3-256
        base_v = ps_cnt;
        beat(2'd1, 1'b1, 8'd0);
        chk("t1_pad_en", pad_en, 1'b1);
        chk("t1_pad_idx", pad_idx, 8'd1);
        chk("t1_pad_mode", pad_mode, 2'd1);
        chk("t1_rate", rate_words, 8'd68);
        tick(); #1;
        chk("t1_perm_start", perm_start, 1'b1);
        tick(); #1;
        chk("t1_pwait_busy", busy, 1'b1);
        repeat (23) tick();
        perm_done = 1'b1;
        #1;
        chk("t1_no_dgst_yet", dgst_valid, 1'b0);
        tick();
        perm_done = 1'b0;
        #1;
        chk("t1_dgst_valid", dgst_valid, 1'b1);
        chk("t1_tready_out", axis.TREADY, 1'b0);
        handshake();
        chk("t1_ps_count", ps_cnt - base_v, 1);

        // exactly one full SHA3-512 block, padding lands in a fresh block
        base_v = ps_cnt;
        for (int i = 0; i < 36; i++) beat(2'd3, (i == 35), 8'(i));
        chk("t2_perm_start_direct", perm_start, 1'b1);
        chk("t2_no_pad_yet", pad_en, 1'b0);
        do_perm(5);
        chk("t2_pad_en", pad_en, 1'b1);
        chk("t2_pad_idx", pad_idx, 8'd0);
        chk("t2_pad_mode", pad_mode, 2'd3);
        tick();
        do_perm(5);
        chk("t2_dgst_valid", dgst_valid, 1'b1);
        chk("t2_ps_count", ps_cnt - base_v, 2);
        handshake();

        // 40 beats of SHA3-512 spill into a second block
        base_v = ps_cnt;
        for (int i = 0; i < 36; i++) beat(2'd3, 1'b0, 8'(i));
        chk("t3_perm_start", perm_start, 1'b1);
        do_perm(3);
        for (int i = 36; i < 40; i++) beat(2'd3, (i == 39), 8'(i - 36));
        chk("t3_pad_en", pad_en, 1'b1);
        chk("t3_pad_idx", pad_idx, 8'd4);
        tick();
        do_perm(3);
        chk("t3_dgst_valid", dgst_valid, 1'b1);
        chk("t3_ps_count", ps_cnt - base_v, 2);
        handshake();

        // gapped SHA3-384 message with TID toggling, slow digest consumer
        base_v = clr_cnt;
        for (int i = 0; i < 10; i++) begin
            if (i == 2 || i == 5 || i == 7) begin
                axis.TVALID = 1'b0;
                axis.TID    = 2'(i);
                #1;
                chk("t4_gap_ld_en", ld_en, 1'b0);
                tick();
            end
            beat((i == 0) ? 2'd2 : 2'(i), (i == 9), 8'(i));
        end
        stall_chk   = 1'b1;
        axis.TVALID = 1'b1;
        axis.TID    = 2'd1;
        #1;
        chk("t4_pad_idx", pad_idx, 8'd10);
        chk("t4_pad_mode", pad_mode, 2'd2);
        chk("t4_rate", rate_words, 8'd52);
        tick();
        do_perm(4);
        for (int i = 0; i < 10; i++) begin
            chk("t4_dgst_hold", dgst_valid, 1'b1);
            chk("t4_tready_hold", axis.TREADY, 1'b0);
            tick(); #1;
        end
        handshake();
        chk("t4_st_clr_pulses", clr_cnt - base_v, 1);
        chk("t4_rdy_during_stall", rdy_bad, 0);
        chk("t4_ld_without_ready", ld_bad, 0);

        // reset while waiting for the permutation
        beat(2'd3, 1'b1, 8'd0);
        tick();
        tick(); #1;
        chk("t5_pwait_busy", busy, 1'b1);
        ARESET = 1'b1;
        tick(); #1;
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_tready", axis.TREADY, 1'b0);
        chk("t5_rst_pad_mode", pad_mode, 2'd0);
        chk("t5_rst_pad_idx", pad_idx, 8'd0);
        chk("t5_rst_rate", rate_words, 8'd72);
        chk("t5_rst_perm_start", perm_start, 1'b0);
        ARESET = 1'b0;
        #1;
        chk("t5_post_tready", axis.TREADY, 1'b1);
        perm_done = 1'b1;
        tick();
        perm_done = 1'b0;
        #1;
        chk("t5_late_done_busy", busy, 1'b0);
        chk("t5_late_done_dgst", dgst_valid, 1'b0);
        chk("t5_late_done_pad", pad_en, 1'b0);

`ifdef SHA3_CTRL_WDT_EN
        // permutation never completes
        beat(2'd0, 1'b1, 8'd0);
        tick();
        tick();
        repeat (63) tick();
        #1;
        chk("t6_err_before", err, 1'b0);
        tick(); #1;
        chk("t6_err", err, 1'b1);
        chk("t6_err_tready", axis.TREADY, 1'b0);
        perm_done = 1'b1;
        tick();
        perm_done = 1'b0;
        #1;
        chk("t6_err_sticky", err, 1'b1);
        chk("t6_err_no_start", perm_start, 1'b0);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        #1;
        chk("t6_err_cleared", err, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
